// File: rtl/spmv_mem_responder.sv
// In-order load/store responder for one SpMV PE memory port.
// Request FIFO -> issue stage (store write / 1-cycle load read) -> response FIFO -> registered output.
module spmv_mem_responder #(
    parameter int unsigned MEM_WORDS_LOG2 = 10,
    parameter int unsigned REQ_DEPTH      = 16,
    parameter int unsigned REQ_SLACK      = 4,
    parameter int unsigned RSP_DEPTH      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_mem_ld,
    input  logic        req_mem_st,
    input  logic [47:0] req_mem_addr,
    input  logic [63:0] req_mem_d_or_tag,
    output logic        req_mem_stall,
    output logic        rsp_mem_push,
    output logic [2:0]  rsp_mem_tag,
    output logic [63:0] rsp_mem_q,
    input  logic        rsp_mem_stall,
    output logic        idle,
    output logic        err
);
    localparam int unsigned MEM_WORDS = 1 << MEM_WORDS_LOG2;
    localparam int unsigned IW        = MEM_WORDS_LOG2;
    localparam int unsigned QPW       = $clog2(REQ_DEPTH);
    localparam int unsigned QCW       = QPW + 1;
    localparam int unsigned SPW       = $clog2(RSP_DEPTH);
    localparam int unsigned SCW       = SPW + 1;
    localparam int unsigned QEW       = 1 + IW + 64;
    localparam int unsigned SEW       = 3 + 64;

    // Storage arrays (no reset: contents are qualified by the pointers/counts)
    logic [QEW-1:0] req_fifo_q [REQ_DEPTH];
    logic [SEW-1:0] rsp_fifo_q [RSP_DEPTH];
    logic [63:0]    mem_q      [MEM_WORDS];
    logic [63:0]    rd_data_q;

    logic [QPW-1:0] req_wr_ptr_q, req_wr_ptr_d, req_rd_ptr_q, req_rd_ptr_d;
    logic [QCW-1:0] req_cnt_q, req_cnt_d;
    logic [SPW-1:0] rsp_wr_ptr_q, rsp_wr_ptr_d, rsp_rd_ptr_q, rsp_rd_ptr_d;
    logic [SCW-1:0] rsp_cnt_q, rsp_cnt_d;
    logic           ld_vld_q, ld_vld_d;
    logic [2:0]     ld_tag_q, ld_tag_d;
    logic           stall_q, stall_d;
    logic           push_q, push_d;
    logic [2:0]     tag_q, tag_d;
    logic [63:0]    q_q, q_d;
    logic           err_q, err_d;

    logic [QEW-1:0] head_c;
    logic           head_st_c;
    logic [IW-1:0]  head_idx_c;
    logic [63:0]    head_data_c;
    logic [IW-1:0]  cap_idx_c;
    logic           cap_c, req_full_c, req_push_c, req_pop_c;
    logic           mem_we_c, mem_re_c, rsp_pop_c;
    logic [SCW:0]   rsp_used_c;
    logic           unused_addr_c;

    assign unused_addr_c = ^{req_mem_addr[47:IW+3], req_mem_addr[2:0]};

    always_comb begin
        head_c       = req_fifo_q[req_rd_ptr_q];
        head_st_c    = head_c[QEW-1];
        head_idx_c   = head_c[64 +: IW];
        head_data_c  = head_c[63:0];
        cap_idx_c    = req_mem_addr[IW+2:3];
        cap_c        = req_mem_ld | req_mem_st;

        // A load may issue only if its response is guaranteed a response-FIFO slot
        rsp_used_c   = (SCW+1)'(rsp_cnt_q) + (SCW+1)'(ld_vld_q);
        req_pop_c    = (req_cnt_q != '0) &&
                       (head_st_c || (rsp_used_c < (SCW+1)'(RSP_DEPTH)));
        req_full_c   = (req_cnt_q == QCW'(REQ_DEPTH));
        req_push_c   = cap_c && (!req_full_c || req_pop_c);
        mem_we_c     = req_pop_c && head_st_c;
        mem_re_c     = req_pop_c && !head_st_c;
        rsp_pop_c    = (rsp_cnt_q != '0) && !rsp_mem_stall;

        req_wr_ptr_d = req_push_c ? req_wr_ptr_q + QPW'(1) : req_wr_ptr_q;
        req_rd_ptr_d = req_pop_c  ? req_rd_ptr_q + QPW'(1) : req_rd_ptr_q;
        req_cnt_d    = req_cnt_q + QCW'(req_push_c) - QCW'(req_pop_c);

        ld_vld_d     = mem_re_c;
        ld_tag_d     = mem_re_c ? head_data_c[2:0] : ld_tag_q;

        rsp_wr_ptr_d = ld_vld_q  ? rsp_wr_ptr_q + SPW'(1) : rsp_wr_ptr_q;
        rsp_rd_ptr_d = rsp_pop_c ? rsp_rd_ptr_q + SPW'(1) : rsp_rd_ptr_q;
        rsp_cnt_d    = rsp_cnt_q + SCW'(ld_vld_q) - SCW'(rsp_pop_c);

        stall_d      = (req_cnt_d >= QCW'(REQ_DEPTH - REQ_SLACK));
        push_d       = rsp_pop_c;
        tag_d        = tag_q;
        q_d          = q_q;
        if (rsp_pop_c) begin
            {tag_d, q_d} = rsp_fifo_q[rsp_rd_ptr_q];
        end
        err_d        = err_q | (req_mem_ld & req_mem_st) | (cap_c & req_full_c & ~req_pop_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_wr_ptr_q <= '0;
            req_rd_ptr_q <= '0;
            req_cnt_q    <= '0;
            rsp_wr_ptr_q <= '0;
            rsp_rd_ptr_q <= '0;
            rsp_cnt_q    <= '0;
            ld_vld_q     <= 1'b0;
            ld_tag_q     <= '0;
            stall_q      <= 1'b0;
            push_q       <= 1'b0;
            tag_q        <= '0;
            q_q          <= '0;
            err_q        <= 1'b0;
        end else begin
            req_wr_ptr_q <= req_wr_ptr_d;
            req_rd_ptr_q <= req_rd_ptr_d;
            req_cnt_q    <= req_cnt_d;
            rsp_wr_ptr_q <= rsp_wr_ptr_d;
            rsp_rd_ptr_q <= rsp_rd_ptr_d;
            rsp_cnt_q    <= rsp_cnt_d;
            ld_vld_q     <= ld_vld_d;
            ld_tag_q     <= ld_tag_d;
            stall_q      <= stall_d;
            push_q       <= push_d;
            tag_q        <= tag_d;
            q_q          <= q_d;
            err_q        <= err_d;
        end
    end

    // Data arrays and the synchronous memory read port
    always_ff @(posedge clk) begin
        if (req_push_c) begin
            req_fifo_q[req_wr_ptr_q] <= {req_mem_st, cap_idx_c, req_mem_d_or_tag};
        end
        if (ld_vld_q) begin
            rsp_fifo_q[rsp_wr_ptr_q] <= {ld_tag_q, rd_data_q};
        end
        if (mem_we_c) begin
            mem_q[head_idx_c] <= head_data_c;
        end
        if (mem_re_c) begin
            rd_data_q <= mem_q[head_idx_c];
        end
    end

    assign req_mem_stall = stall_q;
    assign rsp_mem_push  = push_q;
    assign rsp_mem_tag   = tag_q;
    assign rsp_mem_q     = q_q;
    assign err           = err_q;
    assign idle          = (req_cnt_q == '0) && !ld_vld_q && (rsp_cnt_q == '0);

endmodule

// File: tb/tb_spmv_mem_responder.sv
// Self-checking bench for spmv_mem_responder: directed vector table, corner sequences,
// and a randomized phase checked against a transaction-level memory/response model.
module tb_spmv_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_mem_ld, req_mem_st;
    logic [47:0] req_mem_addr;
    logic [63:0] req_mem_d_or_tag;
    logic        req_mem_stall, rsp_mem_push, rsp_mem_stall, idle, err;
    logic [2:0]  rsp_mem_tag;
    logic [63:0] rsp_mem_q;

    spmv_mem_responder dut (
        .clk(clk), .rst_n(rst_n),
        .req_mem_ld(req_mem_ld), .req_mem_st(req_mem_st),
        .req_mem_addr(req_mem_addr), .req_mem_d_or_tag(req_mem_d_or_tag),
        .req_mem_stall(req_mem_stall), .rsp_mem_push(rsp_mem_push),
        .rsp_mem_tag(rsp_mem_tag), .rsp_mem_q(rsp_mem_q),
        .rsp_mem_stall(rsp_mem_stall), .idle(idle), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [47:0] addr;
        logic [63:0] d;
        logic [63:0] exp_q;
    } vec_t;

    vec_t        vecs [7];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] mdl_mem [int];
    logic [66:0] exp_rsp [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic st, input logic [47:0] a, input logic [63:0] d);
        req_mem_ld       = ld;
        req_mem_st       = st;
        req_mem_addr     = a;
        req_mem_d_or_tag = d;
    endtask

    task automatic watch(input int n, output int cnt, output logic [2:0] tg, output logic [63:0] qv);
        cnt = 0;
        tg  = '0;
        qv  = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rsp_mem_push) begin
                cnt++;
                tg = rsp_mem_tag;
                qv = rsp_mem_q;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] stall_data(input int i);
        return 64'hA5A5_0000_0000_0000 | 64'(i);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt, sent, pushes, j;
        logic        prev, seen;
        logic [2:0]  tg;
        logic [63:0] qv;

        vecs[0] = '{1'b1, 48'h40,            64'h3FF0_0000_0000_0000, 64'h0};
        vecs[1] = '{1'b0, 48'h40,            64'd5,                   64'h3FF0_0000_0000_0000};
        vecs[2] = '{1'b1, 48'h0,             64'hDEAD_BEEF_0123_4567, 64'h0};
        vecs[3] = '{1'b0, 48'h0100_0000_2000, 64'd3,                  64'hDEAD_BEEF_0123_4567};
        vecs[4] = '{1'b1, 48'h8,             64'h1234_5678_9ABC_DEF0, 64'h0};
        vecs[5] = '{1'b0, 48'h8,             64'd2,                   64'h1234_5678_9ABC_DEF0};
        vecs[6] = '{1'b0, 48'h47,            64'd1,                   64'h3FF0_0000_0000_0000};

        rst_n = 1'b0;
        rsp_mem_stall = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        chk("reset_req_stall", 64'(req_mem_stall), 64'd0);
        chk("reset_push",      64'(rsp_mem_push),  64'd0);
        chk("reset_tag",       64'(rsp_mem_tag),   64'd0);
        chk("reset_q",         rsp_mem_q,          64'd0);
        chk("reset_err",       64'(err),           64'd0);
        chk("reset_idle",      64'(idle),          64'd1);
        rst_n = 1'b1;

        // Single requests into an idle block: exact load latency and wrap/offset rules
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(!vecs[i].st, vecs[i].st, vecs[i].addr, vecs[i].d);
            @(negedge clk);
            drive(1'b0, 1'b0, '0, '0);
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                chk($sformatf("vec%0d_push_e%0d", i, k), 64'(rsp_mem_push), 64'((k == 3) && !vecs[i].st));
                if (k == 2 && !vecs[i].st) chk($sformatf("vec%0d_busy", i), 64'(idle), 64'd0);
            end
            if (!vecs[i].st) begin
                chk($sformatf("vec%0d_tag", i), 64'(rsp_mem_tag), 64'(vecs[i].d[2:0]));
                chk($sformatf("vec%0d_q", i),   rsp_mem_q,        vecs[i].exp_q);
            end
            @(negedge clk);
            chk($sformatf("vec%0d_push_after", i), 64'(rsp_mem_push), 64'd0);
            chk($sformatf("vec%0d_idle", i),       64'(idle),         64'd1);
        end

        // Store followed immediately by a load of the same word
        @(negedge clk);
        drive(1'b0, 1'b1, 48'h40, 64'h3FF0_0000_0000_0001);
        @(negedge clk);
        drive(1'b1, 1'b0, 48'h40, 64'd5);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0);
        watch(8, cnt, tg, qv);
        chk("b2b_count", 64'(cnt), 64'd1);
        chk("b2b_tag",   64'(tg),  64'd5);
        chk("b2b_q",     qv,       64'h3FF0_0000_0000_0001);
        chk("b2b_err",   64'(err), 64'd0);

        // Response path stalled: loads back up, request stall rises, then drain in order
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 48'(48'h100 + 48'(i * 8)), stall_data(i));
        end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0);
        rsp_mem_stall = 1'b1;
        sent = 0; pushes = 0; prev = 1'b0; seen = 1'b0;
        for (int c = 0; c < 200 && sent < 20; c++) begin
            @(negedge clk);
            if (rsp_mem_push) pushes++;
            if (req_mem_stall) seen = 1'b1;
            if (!prev) begin
                drive(1'b1, 1'b0, 48'(48'h100 + 48'(sent * 8)), 64'(sent % 8));
                sent++;
            end else begin
                drive(1'b0, 1'b0, '0, '0);
            end
            prev = req_mem_stall;
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, '0, '0);
            if (rsp_mem_push) pushes++;
            if (req_mem_stall) seen = 1'b1;
        end
        chk("stall_sent",   64'(sent),   64'd20);
        chk("stall_seen",   64'(seen),   64'd1);
        chk("stall_pushes", 64'(pushes), 64'd0);
        chk("stall_err",    64'(err),    64'd0);
        rsp_mem_stall = 1'b0;
        j = 0;
        for (int c = 0; c < 100 && j < 20; c++) begin
            @(negedge clk);
            if (rsp_mem_push) begin
                chk($sformatf("drain%0d_tag", j), 64'(rsp_mem_tag), 64'(j % 8));
                chk($sformatf("drain%0d_q", j),   rsp_mem_q,        stall_data(j));
                j++;
            end
        end
        chk("drain_count", 64'(j), 64'd20);

        // Both strobes together: store wins, load dropped, err sticky
        @(negedge clk);
        drive(1'b1, 1'b1, 48'h10, 64'd7);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0);
        watch(5, cnt, tg, qv);
        chk("both_err",    64'(err), 64'd1);
        chk("both_no_rsp", 64'(cnt), 64'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 48'h10, 64'd4);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0);
        watch(6, cnt, tg, qv);
        chk("both_ld_count", 64'(cnt), 64'd1);
        chk("both_ld_tag",   64'(tg),  64'd4);
        chk("both_ld_q",     qv,       64'd7);
        chk("both_err_hold", 64'(err), 64'd1);
        do_reset();
        chk("err_cleared", 64'(err), 64'd0);

        // Overflow: ignore stall with issue blocked by a full response path
        rsp_mem_stall = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 16) chk("ovf_err_early", 64'(err), 64'd0);
            drive(1'b1, 1'b0, 48'h40, 64'(i % 8));
        end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0);
        chk("ovf_err", 64'(err), 64'd1);
        rsp_mem_stall = 1'b0;
        do_reset();

        // Asynchronous reset with loads in the pipeline
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 48'h40, 64'(i + 1));
        end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_push",  64'(rsp_mem_push),  64'd0);
        chk("arst_tag",   64'(rsp_mem_tag),   64'd0);
        chk("arst_q",     rsp_mem_q,          64'd0);
        chk("arst_stall", 64'(req_mem_stall), 64'd0);
        chk("arst_err",   64'(err),           64'd0);
        chk("arst_idle",  64'(idle),          64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        watch(10, cnt, tg, qv);
        chk("arst_no_stale", 64'(cnt),  64'd0);
        chk("arst_idle_post", 64'(idle), 64'd1);

        // Randomized phase against a transaction-level model
        for (int w = 0; w < 32; w++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            mdl_mem[512 + w] = d;
            @(negedge clk);
            drive(1'b0, 1'b1, {35'($urandom), 10'(512 + w), 3'($urandom)}, d);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0);
        prev = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (rsp_mem_push) begin
                if (exp_rsp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rnd_spurious: push tag %0d q %0h with nothing outstanding", rsp_mem_tag, rsp_mem_q);
                end else begin
                    logic [66:0] e;
                    e = exp_rsp.pop_front();
                    chk("rnd_tag", 64'(rsp_mem_tag), 64'(e[66:64]));
                    chk("rnd_q",   rsp_mem_q,        e[63:0]);
                end
            end
            if (c < 2500) begin
                rsp_mem_stall = ($urandom_range(3) == 0);
                if (!prev && $urandom_range(2) != 0) begin
                    int          idx;
                    logic [47:0] a;
                    logic [63:0] d;
                    idx = 512 + int'($urandom_range(31));
                    a   = {35'($urandom), 10'(idx), 3'($urandom)};
                    if ($urandom_range(1) == 1) begin
                        d = {$urandom, $urandom};
                        mdl_mem[idx] = d;
                        drive(1'b0, 1'b1, a, d);
                    end else begin
                        d = 64'($urandom);
                        exp_rsp.push_back({d[2:0], mdl_mem[idx]});
                        drive(1'b1, 1'b0, a, d);
                    end
                end else begin
                    drive(1'b0, 1'b0, '0, '0);
                end
            end else begin
                rsp_mem_stall = 1'b0;
                drive(1'b0, 1'b0, '0, '0);
            end
            prev = req_mem_stall;
        end
        chk("rnd_outstanding", 64'(exp_rsp.size()), 64'd0);
        chk("rnd_err",         64'(err),            64'd0);
        chk("rnd_idle",        64'(idle),           64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
